sha256_gen_padded: RTL and testbench
====================================

# sha256_gen_padded

Builds the single 512-bit SHA-256 padded block for a message of up to 55 bytes. On a go pulse it reads the message byte-by-byte from an external synchronous message SRAM (`sram`). It then applies SHA-256 padding: message bytes, a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It presents the 512-bit block with a ready flag to the downstream SHA-256 compression stage.

## Interface
Parameters:
- MAX_MESSAGE_LENGTH, 55: maximum message bytes; one block needs L+1+8 ≤ 64.
- SYMBOL_WIDTH, 8: bits per message symbol, i.e. the SRAM data width.
- AW (derived), $clog2(MAX_MESSAGE_LENGTH) = 6: width of the length and address fields.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- main_go_sig  in  1  start request, sampled on the rising edge.
- msg_len  in  AW  message length L in bytes; latched when go is accepted.
- msg_mem_data  in  SYMBOL_WIDTH  SRAM read data.
- regop_msg_mem_en  out  1  SRAM enable, registered.
- regop_msg_mem_addr  out  AW  SRAM byte address, registered.
- regop_pad_reg  out  512  padded block, registered.
- regop_pad_rdy  out  1  padded block valid, registered.

SRAM contract (`sram`):
- The SRAM is a synchronous, read-only model here; write is tied to 0.
- When enable=1 at a rising edge, read_data is updated to mem[address] at that edge.
- read_data holds its value otherwise.

## Operation
States:
- IDLE
- FETCH: addresses issued, data captured.
- DONE: block valid.

Transitions:
- IDLE: when main_go_sig=1, latch L = min(msg_len, 55).
  - Clear regop_pad_reg, then load bits [63:0] with L×8 (zero-extended).
  - If L=0: write 0x80 into byte 0 and go to DONE.
  - Otherwise: set en=1, addr=0, and go to FETCH.
- FETCH: issue addr = 0,1,…,L-1 on successive cycles.
  - Once addr L-1 has been issued, deassert en and return addr to 0.
  - Capture each returned byte k into byte lane k.
  - On the edge that captures byte L-1, also write 0x80 into byte lane L and go to DONE.
- DONE: regop_pad_rdy=1 and regop_pad_reg is held stable.
  - main_go_sig=1 in DONE starts a new run exactly as from IDLE, and rdy drops on that edge.

Packing and arithmetic:
- Byte lane i is regop_pad_reg[511-8i -: 8]; message byte 0 is most significant.
- Lanes L+1 through 55 and all unused length bits are zero.
- The length field is (L<<3), 64 bits wide, with the upper bits zero.

Boundary conditions:
- main_go_sig while in FETCH is ignored, and msg_len is not re-sampled.
- main_go_sig held high continuously causes back-to-back runs, with one DONE cycle between runs.
- msg_len changes after go is accepted have no effect.
- msg_len > 55 is clamped to 55.
- Reset asserted mid-run aborts to IDLE with all outputs at their reset values.

## Timing
Reset values:
- regop_msg_mem_en = 0
- regop_msg_mem_addr = 0
- regop_pad_reg = 0
- regop_pad_rdy = 0
- state = IDLE

Cycle-level sequence, with E0 the edge where go is accepted:
- E0: en=1, addr=0.
- Edge E0+k (k=1..L-1): addr=k. At E0+L, en=0.
- Edge E0+1+k: the SRAM outputs byte k.
- Edge E0+2+k: the padder captures byte k.
- Edge E0+L+1: the last byte is captured, 0x80 is inserted, state enters DONE, and rdy=1.

Latency:
- Go edge to rdy high is L+1 edges; for L=55 that is 56 cycles.
- For L=0, rdy is high at E0.

rdy behaviour:
- rdy is a level signal, not a pulse.
- It stays high until the next accepted go or reset.

## Test plan
- L=3, memory "abc": the block is 0x61626380 followed by zeros, ending in the 64-bit value 0x18. rdy rises 4 edges after go; exactly 3 enabled reads occur, at addresses 0,1,2.
- L=55, memory from message55.dat: bytes 0–54 match the file, lane 55 is 0x80, and [63:0] = 0x1B8. Then issue a second go about 600 ns later: rdy drops, then an identical block is produced again.
- L=0: the block is 0x80 followed by zeros with length 0, rdy is high one edge after go, and no SRAM enable is asserted.
- Pulse go again 20 ns into a FETCH with L=55: the run is unaffected, the result and latency match a single go, and msg_len changed mid-run is ignored.
- Go held high continuously with L=55: repeated runs occur, each DONE cycle shows the correct block, and en/addr restart at 0.
- Assert reset at cycle 20 of a run: all outputs go to 0 immediately and asynchronously. A subsequent go produces a correct block.

Source files
------------

// File: rtl/sha256_gen_padded.sv
// rtl/sha256_gen_padded.sv - SHA-256 single-block padder fed from a synchronous message SRAM
//
// Purpose: on main_go_sig, fetches L = min(msg_len, MAX_MESSAGE_LENGTH) bytes from the
// message SRAM and builds the 512-bit padded block. The block holds the message bytes,
// then 0x80, then zero fill, then the 64-bit big-endian bit length.
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous active-low reset
//   main_go_sig        start request (accepted in IDLE or DONE)
//   msg_len            message length in bytes, latched on an accepted go
//   msg_mem_data       SRAM read data (valid one edge after an enabled read)
//   regop_msg_mem_en   SRAM read enable
//   regop_msg_mem_addr SRAM byte address
//   regop_pad_reg      padded block, byte lane i at [511-8i -: 8]
//   regop_pad_rdy      block valid level, high in DONE
module sha256_gen_padded #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  parameter int SYMBOL_WIDTH       = 8,
  localparam int AW                = $clog2(MAX_MESSAGE_LENGTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    main_go_sig,
  input  logic [AW-1:0]           msg_len,
  input  logic [SYMBOL_WIDTH-1:0] msg_mem_data,
  output logic                    regop_msg_mem_en,
  output logic [AW-1:0]           regop_msg_mem_addr,
  output logic [511:0]            regop_pad_reg,
  output logic                    regop_pad_rdy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] len_q;      // latched message length
  logic [AW-1:0] cap_idx;    // index of the next byte to capture
  logic          rd_vld;     // SRAM performed a read on the previous edge

  logic [AW-1:0] len_clamp;
  logic [63:0]   len_field;
  logic [AW-1:0] pad_lane;
  logic [9:0]    cap_pos;
  logic [9:0]    pad_pos;

  always_comb begin
    len_clamp = msg_len;
    if (msg_len > AW'(MAX_MESSAGE_LENGTH)) begin
      len_clamp = AW'(MAX_MESSAGE_LENGTH);
    end
  end

  assign len_field = {{(61-AW){1'b0}}, len_clamp, 3'b000};
  // The 0x80 marker follows the last captured byte, so it lands in lane cap_idx+1.
  assign pad_lane  = cap_idx + 1'b1;
  assign cap_pos   = 10'd511 - {{(7-AW){1'b0}}, cap_idx, 3'b000};
  assign pad_pos   = 10'd511 - {{(7-AW){1'b0}}, pad_lane, 3'b000};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      len_q              <= '0;
      cap_idx            <= '0;
      rd_vld             <= 1'b0;
      regop_msg_mem_en   <= 1'b0;
      regop_msg_mem_addr <= '0;
      regop_pad_reg      <= '0;
      regop_pad_rdy      <= 1'b0;
    end else begin
      // The SRAM returns data one edge after an enabled read, so the capture
      // qualifier is simply the enable delayed by one edge.
      rd_vld <= regop_msg_mem_en;

      case (state)
        IDLE, DONE: begin
          if (main_go_sig) begin
            len_q         <= len_clamp;
            cap_idx       <= '0;
            regop_pad_rdy <= 1'b0;
            if (len_clamp == '0) begin
              regop_pad_reg <= {8'h80, 440'b0, len_field};
              regop_pad_rdy <= 1'b1;
              state         <= DONE;
            end else begin
              regop_pad_reg      <= {448'b0, len_field};
              regop_msg_mem_en   <= 1'b1;
              regop_msg_mem_addr <= '0;
              state              <= FETCH;
            end
          end
        end

        FETCH: begin
          // Address issue runs ahead of capture by two edges.
          if (regop_msg_mem_en) begin
            if (regop_msg_mem_addr == len_q - 1'b1) begin
              regop_msg_mem_en   <= 1'b0;
              regop_msg_mem_addr <= '0;
            end else begin
              regop_msg_mem_addr <= regop_msg_mem_addr + 1'b1;
            end
          end

          if (rd_vld) begin
            regop_pad_reg[cap_pos -: SYMBOL_WIDTH] <= msg_mem_data;
            cap_idx <= cap_idx + 1'b1;
            if (cap_idx == len_q - 1'b1) begin
              regop_pad_reg[pad_pos -: 8] <= 8'h80;
              regop_pad_rdy               <= 1'b1;
              state                       <= DONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_gen_padded.sv
// tb/tb_sha256_gen_padded.sv - directed self-checking bench for sha256_gen_padded
module tb_sha256_gen_padded;

  logic         clock;
  logic         reset;
  logic         main_go_sig;
  logic [5:0]   msg_len;
  logic [7:0]   msg_mem_data;
  logic         regop_msg_mem_en;
  logic [5:0]   regop_msg_mem_addr;
  logic [511:0] regop_pad_reg;
  logic         regop_pad_rdy;

  int tests;
  int fails;

  logic [7:0] mem [0:63];
  int         rd_count;
  int         addr_log [0:4095];

  sha256_gen_padded dut (
    .clock              (clock),
    .reset              (reset),
    .main_go_sig        (main_go_sig),
    .msg_len            (msg_len),
    .msg_mem_data       (msg_mem_data),
    .regop_msg_mem_en   (regop_msg_mem_en),
    .regop_msg_mem_addr (regop_msg_mem_addr),
    .regop_pad_reg      (regop_pad_reg),
    .regop_pad_rdy      (regop_pad_rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SRAM model
  always @(posedge clock) begin
    if (regop_msg_mem_en) msg_mem_data <= mem[regop_msg_mem_addr];
  end

  // Log every enabled read address
  initial rd_count = 0;
  always @(posedge clock) begin
    if (regop_msg_mem_en) begin
      if (rd_count < 4096) addr_log[rd_count] = int'(regop_msg_mem_addr);
      rd_count = rd_count + 1;
    end
  end

  function automatic logic [511:0] exp_block(input int l);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < l; i++) b[511-8*i -: 8] = mem[i];
    b[511-8*l -: 8] = 8'h80;
    b[63:0] = 64'(l * 8);
    return b;
  endfunction

  task automatic start_go(input int l);
    @(negedge clock);
    msg_len     = 6'(l);
    main_go_sig = 1'b1;
    @(posedge clock);
    @(negedge clock);
    main_go_sig = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!regop_pad_rdy && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic fill_mem55();
    for (int i = 0; i < 64; i++) mem[i] = 8'((i * 37 + 11) ^ 8'h5A);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    main_go_sig = 1'b0;
    msg_len = '0;
    repeat (2) @(negedge clock);
    tests++; if (regop_msg_mem_en !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", regop_msg_mem_en); end
    tests++; if (regop_msg_mem_addr !== 6'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", regop_msg_mem_addr); end
    tests++; if (regop_pad_reg !== 512'd0) begin fails++; $display("FAIL reset_pad got %h want 0", regop_pad_reg); end
    tests++; if (regop_pad_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b want 0", regop_pad_rdy); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_abc();
    int lat, base;
    logic [511:0] want;
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    want = {32'h61626380, 416'b0, 64'h18};
    base = rd_count;
    start_go(3);
    wait_rdy(lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL abc_latency got %0d want 4", lat); end
    tests++; if (regop_pad_reg !== want) begin fails++; $display("FAIL abc_block got %h want %h", regop_pad_reg, want); end
    tests++; if (rd_count - base !== 3) begin fails++; $display("FAIL abc_reads got %0d want 3", rd_count - base); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (addr_log[base+k] !== k) begin fails++; $display("FAIL abc_addr%0d got %0d want %0d", k, addr_log[base+k], k); end
    end
  endtask

  task automatic test_len55();
    int lat, base;
    fill_mem55();
    base = rd_count;
    start_go(55);
    wait_rdy(lat);
    tests++; if (lat !== 56) begin fails++; $display("FAIL l55_latency got %0d want 56", lat); end
    tests++; if (regop_pad_reg !== exp_block(55)) begin fails++; $display("FAIL l55_block got %h want %h", regop_pad_reg, exp_block(55)); end
    tests++; if (regop_pad_reg[511-8*55 -: 8] !== 8'h80) begin fails++; $display("FAIL l55_marker got %h want 80", regop_pad_reg[511-8*55 -: 8]); end
    tests++; if (regop_pad_reg[63:0] !== 64'h1B8) begin fails++; $display("FAIL l55_length got %h want 1b8", regop_pad_reg[63:0]); end
    tests++; if (rd_count - base !== 55) begin fails++; $display("FAIL l55_reads got %0d want 55", rd_count - base); end
    tests++; if (addr_log[base+54] !== 54) begin fails++; $display("FAIL l55_lastaddr got %0d want 54", addr_log[base+54]); end
    repeat (60) @(negedge clock);
    start_go(55);
    tests++; if (regop_pad_rdy !== 1'b0) begin fails++; $display("FAIL l55_rdy_drop got %b want 0", regop_pad_rdy); end
    wait_rdy(lat);
    tests++; if (lat !== 56) begin fails++; $display("FAIL l55_rerun_latency got %0d want 56", lat); end
    tests++; if (regop_pad_reg !== exp_block(55)) begin fails++; $display("FAIL l55_rerun_block got %h want %h", regop_pad_reg, exp_block(55)); end
  endtask

  task automatic test_len0();
    int lat, base;
    logic [511:0] want;
    want = {8'h80, 504'b0};
    base = rd_count;
    start_go(0);
    wait_rdy(lat);
    tests++; if (lat !== 0) begin fails++; $display("FAIL l0_latency got %0d want 0", lat); end
    tests++; if (regop_pad_reg !== want) begin fails++; $display("FAIL l0_block got %h want %h", regop_pad_reg, want); end
    repeat (3) @(negedge clock);
    tests++; if (rd_count - base !== 0) begin fails++; $display("FAIL l0_reads got %0d want 0", rd_count - base); end
    tests++; if (regop_pad_rdy !== 1'b1) begin fails++; $display("FAIL l0_rdy_level got %b want 1", regop_pad_rdy); end
  endtask

  task automatic test_go_during_fetch();
    int lat, base;
    fill_mem55();
    base = rd_count;
    start_go(55);
    @(negedge clock);
    msg_len = 6'd3;
    main_go_sig = 1'b1;
    @(negedge clock);
    main_go_sig = 1'b0;
    msg_len = 6'd10;
    wait_rdy(lat);
    lat = lat + 2;
    tests++; if (lat !== 56) begin fails++; $display("FAIL gofetch_latency got %0d want 56", lat); end
    tests++; if (regop_pad_reg !== exp_block(55)) begin fails++; $display("FAIL gofetch_block got %h want %h", regop_pad_reg, exp_block(55)); end
    tests++; if (rd_count - base !== 55) begin fails++; $display("FAIL gofetch_reads got %0d want 55", rd_count - base); end
  endtask

  task automatic test_go_held();
    int lat, base;
    fill_mem55();
    @(negedge clock);
    msg_len = 6'd55;
    main_go_sig = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wait_rdy(lat);
    tests++; if (lat !== 56) begin fails++; $display("FAIL held_run1_latency got %0d want 56", lat); end
    tests++; if (regop_pad_reg !== exp_block(55)) begin fails++; $display("FAIL held_run1_block got %h want %h", regop_pad_reg, exp_block(55)); end
    base = rd_count;
    @(negedge clock);
    tests++; if (regop_pad_rdy !== 1'b0) begin fails++; $display("FAIL held_rdy_drop got %b want 0", regop_pad_rdy); end
    tests++; if (regop_msg_mem_en !== 1'b1 || regop_msg_mem_addr !== 6'd0) begin fails++; $display("FAIL held_restart got en=%b addr=%0d want en=1 addr=0", regop_msg_mem_en, regop_msg_mem_addr); end
    wait_rdy(lat);
    tests++; if (lat !== 56) begin fails++; $display("FAIL held_run2_latency got %0d want 56", lat); end
    tests++; if (regop_pad_reg !== exp_block(55)) begin fails++; $display("FAIL held_run2_block got %h want %h", regop_pad_reg, exp_block(55)); end
    tests++; if (addr_log[base] !== 0 || addr_log[base+54] !== 54) begin fails++; $display("FAIL held_run2_addr got %0d..%0d want 0..54", addr_log[base], addr_log[base+54]); end
    main_go_sig = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_clamp();
    int lat;
    fill_mem55();
    start_go(63);
    wait_rdy(lat);
    tests++; if (lat !== 56) begin fails++; $display("FAIL clamp_latency got %0d want 56", lat); end
    tests++; if (regop_pad_reg !== exp_block(55)) begin fails++; $display("FAIL clamp_block got %h want %h", regop_pad_reg, exp_block(55)); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    fill_mem55();
    start_go(55);
    repeat (19) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    tests++; if (regop_msg_mem_en !== 1'b0 || regop_msg_mem_addr !== 6'd0) begin fails++; $display("FAIL midreset_en_addr got en=%b addr=%0d want 0 0", regop_msg_mem_en, regop_msg_mem_addr); end
    tests++; if (regop_pad_reg !== 512'd0 || regop_pad_rdy !== 1'b0) begin fails++; $display("FAIL midreset_pad_rdy got rdy=%b pad=%h want 0", regop_pad_rdy, regop_pad_reg); end
    @(negedge clock);
    reset = 1'b1;
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF; mem[4] = 8'h42;
    start_go(5);
    wait_rdy(lat);
    tests++; if (lat !== 6) begin fails++; $display("FAIL postreset_latency got %0d want 6", lat); end
    tests++; if (regop_pad_reg !== {48'hDEADBEEF4280, 400'b0, 64'h28}) begin fails++; $display("FAIL postreset_block got %h want %h", regop_pad_reg, {48'hDEADBEEF4280, 400'b0, 64'h28}); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_abc();
    test_len55();
    test_len0();
    test_go_during_fetch();
    test_go_held();
    test_clamp();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
